// File: rtl/fsm_pkg.sv
// Shared constants for the Mealy sequence FSM and its y-bit collector.
package fsm_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned DEPTH_DEF = 4;

   // Collector states
   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] PUSH    = 1'b1;

endpackage

// File: rtl/fsm_word_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty, and same-cycle push/pop when full.
module fsm_word_fifo #(
   parameter int unsigned DW    = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_push,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_pop,
   output logic [DW-1:0] o_rdata,
   output logic          o_empty,
   output logic          o_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic          w_wr_en;
   logic          w_rd_en;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   // A pop frees the slot the simultaneous push needs, so full does not block it.
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);

   // Forcing zero while empty keeps the head clean after reset without clearing storage.
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_rd_en) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

endmodule

// File: rtl/fsm_y_collector.sv
// Packs the FSM's serial y bits LSB-first into words with a ones count and queues them.
module fsm_y_collector
   import fsm_pkg::*;
#(
   parameter int unsigned  WIDTH = WIDTH_DEF,
   parameter int unsigned  DEPTH = DEPTH_DEF,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_y_in,
   input  logic             i_y_valid,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_word_out,
   output logic [CNT_W-1:0] o_ones_out,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [CNT_W-1:0] o_fill,
   output logic             o_overflow
);

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [0:0]       r_state;
   logic [0:0]       w_state_d;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] w_shift_d;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_d;
   logic [CNT_W-1:0] r_fill;
   logic [CNT_W-1:0] w_fill_d;
   logic [WIDTH-1:0] r_hold_word;
   logic [WIDTH-1:0] w_hold_word_d;
   logic [CNT_W-1:0] r_hold_ones;
   logic [CNT_W-1:0] w_hold_ones_d;
   logic             r_overflow;

   logic [WIDTH-1:0] w_bit_word;
   logic [CNT_W-1:0] w_bit_count;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic             w_full;
   logic [WIDTH+CNT_W-1:0] w_fifo_rdata;

   assign w_bit_word  = r_shift | (WIDTH'(i_y_in) << r_fill);
   assign w_bit_count = r_count + CNT_W'(i_y_in);

   // Bit acceptance is identical in COLLECT and PUSH; PUSH only adds the FIFO write.
   always_comb begin
      w_state_d     = COLLECT;
      w_shift_d     = r_shift;
      w_count_d     = r_count;
      w_fill_d      = r_fill;
      w_hold_word_d = r_hold_word;
      w_hold_ones_d = r_hold_ones;
      if (i_flush) begin
         w_shift_d = '0;
         w_count_d = '0;
         w_fill_d  = '0;
      end else if (i_y_valid) begin
         if (r_fill == FILL_LAST) begin
            w_hold_word_d = w_bit_word;
            w_hold_ones_d = w_bit_count;
            w_shift_d     = '0;
            w_count_d     = '0;
            w_fill_d      = '0;
            w_state_d     = PUSH;
         end else begin
            w_shift_d = w_bit_word;
            w_count_d = w_bit_count;
            w_fill_d  = r_fill + CNT_ONE;
         end
      end
   end

   assign w_push = (r_state == PUSH);
   assign w_pop  = o_out_valid && i_out_ready;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= COLLECT;
         r_shift     <= '0;
         r_count     <= '0;
         r_fill      <= '0;
         r_hold_word <= '0;
         r_hold_ones <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_shift     <= w_shift_d;
         r_count     <= w_count_d;
         r_fill      <= w_fill_d;
         r_hold_word <= w_hold_word_d;
         r_hold_ones <= w_hold_ones_d;
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   fsm_word_fifo #(
      .DW    (WIDTH + CNT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_wdata ({r_hold_word, r_hold_ones}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign o_word_out  = w_fifo_rdata[WIDTH+CNT_W-1:CNT_W];
   assign o_ones_out  = w_fifo_rdata[CNT_W-1:0];
   assign o_out_valid = !w_empty;
   assign o_fill      = r_fill;
   assign o_overflow  = r_overflow;

endmodule
